alu_issue_stage: RTL

//  Issue stage directly upstream of the combinational ALU. Accepts operand/opcode

---
 rtl/alu_issue_stage.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/alu_issue_stage.sv
// alu_issue_stage
//   Issue stage sitting directly in front of the combinational ALU. Triplets
//   (op1, op2, opcode) arrive from decode over a valid/ready handshake. They are
//   held in a 2-entry skid buffer (main + skid), and one stable triplet at a time
//   is presented to the ALU. Opcodes above MAX_OPC are accepted, dropped and counted.
//   They are never issued.
//
// Handshake: a transfer happens on a rising edge where valid and ready are both 1.
//   valid must not depend on ready. in_ready is decoded from state only, so there
//   is no combinational path from out_ready to in_ready.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   flush               synchronous clear of buffered entries
//   in_valid/in_ready   upstream handshake; in_op1, in_op2, in_opcode payload
//   out_valid/out_ready downstream handshake; alu_op1, alu_op2, alu_opcode payload
//   err_illegal         1-cycle pulse after an illegal opcode was dropped
//   issue_cnt           triplets issued, wraps
//   illegal_cnt         illegal opcodes dropped, saturates at all-ones
module alu_issue_stage #(
    parameter int DATA_W  = 32,
    parameter int OPC_W   = 4,
    parameter int MAX_OPC = 5,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_op1,
    input  logic [DATA_W-1:0] in_op2,
    input  logic [OPC_W-1:0]  in_opcode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] alu_op1,
    output logic [DATA_W-1:0] alu_op2,
    output logic [OPC_W-1:0]  alu_opcode,
    output logic              err_illegal,
    output logic [CNT_W-1:0]  issue_cnt,
    output logic [CNT_W-1:0]  illegal_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [DATA_W-1:0] main_op1, main_op2, skid_op1, skid_op2;
    logic [OPC_W-1:0]  main_opc, skid_opc;

    logic legal, push, pop, drop;
    logic load_main_in, load_skid_in, load_main_skid;

    assign in_ready  = (state != TWO);
    assign out_valid = (state != EMPTY);

    assign legal = (in_opcode <= OPC_W'(MAX_OPC));
    assign push  = in_valid & in_ready & legal;
    assign drop  = in_valid & in_ready & ~legal;
    assign pop   = out_valid & out_ready;

    // The ALU always looks at the main register, which keeps its value after
    // the last pop and across flush.
    assign alu_op1    = main_op1;
    assign alu_op2    = main_op2;
    assign alu_opcode = main_opc;

    always_comb begin
        state_nxt      = state;
        load_main_in   = 1'b0;
        load_skid_in   = 1'b0;
        load_main_skid = 1'b0;
        case (state)
            EMPTY: begin
                if (push) begin
                    state_nxt    = ONE;
                    load_main_in = 1'b1;
                end
            end
            ONE: begin
                if (push && pop) begin
                    load_main_in = 1'b1;
                end else if (push) begin
                    state_nxt    = TWO;
                    load_skid_in = 1'b1;
                end else if (pop) begin
                    state_nxt = EMPTY;
                end
            end
            TWO: begin
                if (pop) begin
                    state_nxt      = ONE;
                    load_main_skid = 1'b1;
                end
            end
            default: state_nxt = EMPTY;
        endcase
        // Flush wins over any push/pop in the same cycle. The popped triplet has
        // still been consumed downstream, so only the counters see it.
        if (flush) begin
            state_nxt      = EMPTY;
            load_main_in   = 1'b0;
            load_skid_in   = 1'b0;
            load_main_skid = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_op1 <= '0;
            main_op2 <= '0;
            main_opc <= '0;
            skid_op1 <= '0;
            skid_op2 <= '0;
            skid_opc <= '0;
        end else begin
            if (load_main_in) begin
                main_op1 <= in_op1;
                main_op2 <= in_op2;
                main_opc <= in_opcode;
            end else if (load_main_skid) begin
                main_op1 <= skid_op1;
                main_op2 <= skid_op2;
                main_opc <= skid_opc;
            end
            if (load_skid_in) begin
                skid_op1 <= in_op1;
                skid_op2 <= in_op2;
                skid_opc <= in_opcode;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_illegal <= 1'b0;
            issue_cnt   <= '0;
            illegal_cnt <= '0;
        end else begin
            err_illegal <= drop;
            if (pop) begin
                issue_cnt <= issue_cnt + 1'b1;
            end
            if (drop && (illegal_cnt != '1)) begin
                illegal_cnt <= illegal_cnt + 1'b1;
            end
        end
    end

endmodule
